// File: rtl/alu_issue_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl_pkg
// Description : Shared types and constants for the ALU issue controller:
//               FSM state encoding, key length and the CLR opcode that is
//               driven to the ALU whenever no operation is executing.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_issue_ctrl_pkg;

    // FSM state encoding; explicit width keeps the state register at 2 bits.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Number of serial bits that make up the ALU locking key.
    localparam int KEY_BITS = 8;

    // Opcode presented to the ALU outside EXEC.
    localparam logic [3:0] OP_CLR = 4'b0000;

endpackage : alu_issue_ctrl_pkg
`default_nettype wire

// File: rtl/lock_key_loader.sv
`default_nettype none
// ============================================================================
// Module      : lock_key_loader
// Description : Serial MSB-first loader for the ALU locking key. A 4-bit bit
//               counter saturates at KEY_BITS; key_loaded is high once a full
//               key has been shifted in. Shifting continues after that point.
// Ports       : clk, rst_n      - clock, async active-low reset
//               key_sin        - serial key bit
//               key_shift_en   - shift enable (already gated by the caller)
//               locking_key    - key register
//               key_loaded     - full key has been received
// Revision    : 1.0 - initial release
// ============================================================================
module lock_key_loader
    import alu_issue_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                key_sin,
    input  logic                key_shift_en,
    output logic [KEY_BITS-1:0] locking_key,
    output logic                key_loaded
);

    localparam logic [3:0] C_CNT_FULL = 4'(KEY_BITS);

    logic [KEY_BITS-1:0] key_q, key_d;
    logic [3:0]          bit_cnt_q, bit_cnt_d;

    always_comb begin
        key_d     = key_q;
        bit_cnt_d = bit_cnt_q;
        if (key_shift_en) begin
            key_d = {key_q[KEY_BITS-2:0], key_sin};
            // Counter stops at KEY_BITS so key_loaded stays high on extra shifts.
            if (bit_cnt_q != C_CNT_FULL) begin
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q     <= '0;
            bit_cnt_q <= '0;
        end else begin
            key_q     <= key_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign locking_key = key_q;
    assign key_loaded  = (bit_cnt_q == C_CNT_FULL);

endmodule : lock_key_loader
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_ctrl
// Description : Sequential command front-end for the 8-bit ALU. Accepts
//               load/execute commands, drives the ALU from an accumulator
//               (ACC) and operand register (BR), writes Y back into ACC for
//               cmd_rep+1 cycles and returns ACC over a result handshake.
//               Also hosts the serial locking-key loader.
// Ports       : clk, rst_n                 - clock, async active-low reset
//               key_sin, key_shift         - serial key input
//               locking_key, key_loaded    - key register and status
//               cmd_*                      - command handshake and fields
//               alu_a, alu_b, alu_opcode   - ALU operand/opcode drive
//               alu_y                      - ALU result
//               res_valid, res_ready       - result handshake
//               res_data, res_zero         - ACC and ACC==0 flag
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DW = 8,
    parameter int RW = 3
) (
    input  logic                clk,
    input  logic                rst_n,
    // key loader
    input  logic                key_sin,
    input  logic                key_shift,
    output logic [KEY_BITS-1:0] locking_key,
    output logic                key_loaded,
    // command channel
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_load,
    input  logic [3:0]          cmd_op,
    input  logic [DW-1:0]       cmd_data,
    input  logic [RW-1:0]       cmd_rep,
    // ALU drive
    output logic [DW-1:0]       alu_a,
    output logic [DW-1:0]       alu_b,
    output logic [3:0]          alu_opcode,
    input  logic [DW-1:0]       alu_y,
    // result channel
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DW-1:0]       res_data,
    output logic                res_zero
);

    state_t         state_q, state_d;
    logic [DW-1:0]  acc_q, acc_d;
    logic [DW-1:0]  br_q,  br_d;
    logic [3:0]     opr_q, opr_d;
    logic [RW-1:0]  cnt_q, cnt_d;

    logic           w_cmd_fire;
    logic           w_key_shift_en;

    // Key may only change while idle so an executing op never sees a new key.
    assign w_key_shift_en = key_shift & (state_q == ST_IDLE);

    lock_key_loader u_key_loader (
        .clk          (clk),
        .rst_n        (rst_n),
        .key_sin      (key_sin),
        .key_shift_en (w_key_shift_en),
        .locking_key  (locking_key),
        .key_loaded   (key_loaded)
    );

    assign w_cmd_fire = cmd_valid & cmd_ready;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    state_d = cmd_load ? ST_RESP : ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    always_comb begin
        cmd_ready  = 1'b0;
        res_valid  = 1'b0;
        alu_opcode = OP_CLR;
        unique case (state_q)
            ST_IDLE: cmd_ready  = key_loaded;
            ST_EXEC: alu_opcode = opr_q;
            ST_RESP: res_valid  = 1'b1;
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_comb begin
        acc_d = acc_q;
        br_d  = br_q;
        opr_d = opr_q;
        cnt_d = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (w_cmd_fire) begin
                    opr_d = cmd_op;
                    br_d  = cmd_data;
                    cnt_d = cmd_rep;
                    if (cmd_load) begin
                        acc_d = cmd_data;
                    end
                end
            end
            ST_EXEC: begin
                // ALU wrap-around is taken as-is; no carry is retained.
                acc_d = alu_y;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - RW'(1);
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            br_q  <= '0;
            opr_q <= '0;
            cnt_q <= '0;
        end else begin
            acc_q <= acc_d;
            br_q  <= br_d;
            opr_q <= opr_d;
            cnt_q <= cnt_d;
        end
    end

    assign alu_a    = acc_q;
    assign alu_b    = br_q;
    assign res_data = acc_q;
    assign res_zero = (acc_q == '0);

endmodule : alu_issue_ctrl
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_issue_ctrl
// Description : Self-checking bench for alu_issue_ctrl. A behavioural ALU
//               model closes the loop on alu_a/alu_b/alu_opcode -> alu_y.
//               Expected results are queued at command acceptance and popped
//               when the result handshake completes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int DW = 8;
    localparam int RW = 3;

    localparam logic [3:0] OP_SHL = 4'b1000;
    localparam logic [3:0] OP_ROL = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b1111;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          key_sin, key_shift;
    logic [7:0]    locking_key;
    logic          key_loaded;
    logic          cmd_valid, cmd_ready, cmd_load;
    logic [3:0]    cmd_op;
    logic [DW-1:0] cmd_data;
    logic [RW-1:0] cmd_rep;
    logic [DW-1:0] alu_a, alu_b, alu_y;
    logic [3:0]    alu_opcode;
    logic          res_valid, res_ready, res_zero;
    logic [DW-1:0] res_data;

    int            total = 0;
    int            bad   = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] acc_model;

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] alu_f(input logic [DW-1:0] a,
                                            input logic [DW-1:0] b,
                                            input logic [3:0] op);
        case (op)
            4'b0000: alu_f = '0;
            OP_SHL:  alu_f = {a[DW-2:0], 1'b0};
            OP_ROL:  alu_f = {a[DW-2:0], a[DW-1]};
            OP_AND:  alu_f = a & b;
            default: alu_f = a;
        endcase
    endfunction

    assign alu_y = alu_f(alu_a, alu_b, alu_opcode);

    alu_issue_ctrl #(.DW(DW), .RW(RW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_sin     (key_sin),
        .key_shift   (key_shift),
        .locking_key (locking_key),
        .key_loaded  (key_loaded),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_load    (cmd_load),
        .cmd_op      (cmd_op),
        .cmd_data    (cmd_data),
        .cmd_rep     (cmd_rep),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_opcode  (alu_opcode),
        .alu_y       (alu_y),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_data    (res_data),
        .res_zero    (res_zero)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Result monitor: sampled just after the falling edge so that res_ready
    // updates made by the stimulus on the same edge are already visible.
    always @(negedge clk) begin
        #1;
        if (res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 32'(res_data), 32'hFFFF_FFFF);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                check("res_data", 32'(res_data), 32'(e));
                check("res_zero", 32'(res_zero), 32'(e == '0));
            end
        end
    end

    task automatic load_key(input logic [7:0] key);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk);
            check("ready_before_key", 32'(cmd_ready), 32'd0);
            check("loaded_before_key", 32'(key_loaded), 32'd0);
            key_shift = 1'b1;
            key_sin   = key[i];
        end
        @(negedge clk);
        key_shift = 1'b0;
        key_sin   = 1'b0;
        check("locking_key", 32'(locking_key), 32'(key));
        check("key_loaded", 32'(key_loaded), 32'd1);
        check("ready_after_key", 32'(cmd_ready), 32'd1);
    endtask

    // Issue one command, track ACC steps during EXEC and the accept-to-valid
    // latency; returns once res_valid is seen.
    task automatic send_cmd(input logic ld, input logic [3:0] op,
                            input logic [DW-1:0] data, input logic [RW-1:0] rep);
        int            n;
        logic [DW-1:0] step;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_load  = ld;
        cmd_op    = op;
        cmd_data  = data;
        cmd_rep   = rep;
        n = 0;
        while (!cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept_wait", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        step = acc_model;
        if (ld) begin
            acc_model = data;
        end else begin
            for (int k = 0; k <= int'(rep); k++) acc_model = alu_f(acc_model, data, op);
        end
        exp_q.push_back(acc_model);
        @(negedge clk);
        cmd_valid = 1'b0;
        n = 0;
        while (!res_valid && n < 20) begin
            check("acc_step", 32'(res_data), 32'(step));
            check("opcode_exec", 32'(alu_opcode), 32'(op));
            @(negedge clk);
            n++;
            step = alu_f(step, data, op);
        end
        check("latency", 32'(n), ld ? 32'd0 : 32'(rep) + 32'd1);
    endtask

    initial begin
        rst_n     = 1'b0;
        key_sin   = 1'b0;
        key_shift = 1'b0;
        cmd_valid = 1'b0;
        cmd_load  = 1'b0;
        cmd_op    = '0;
        cmd_data  = '0;
        cmd_rep   = '0;
        res_ready = 1'b1;
        acc_model = '0;

        repeat (3) @(negedge clk);
        check("rst_key_loaded", 32'(key_loaded), 32'd0);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_data", 32'(res_data), 32'h00);
        check("rst_res_zero", 32'(res_zero), 32'd1);
        check("rst_opcode", 32'(alu_opcode), 32'd0);
        check("rst_key", 32'(locking_key), 32'd0);
        rst_n = 1'b1;

        load_key(8'hD2);

        send_cmd(1'b1, 4'd0, 8'h03, 3'd0);
        send_cmd(1'b0, OP_SHL, 8'h00, 3'd2);
        send_cmd(1'b1, 4'd0, 8'h81, 3'd0);
        send_cmd(1'b0, OP_ROL, 8'h00, 3'd0);
        send_cmd(1'b1, 4'd0, 8'h3C, 3'd0);
        send_cmd(1'b0, OP_AND, 8'h0F, 3'd0);

        // Back-pressure with a zero result; a command pulse must be ignored.
        @(negedge clk);
        res_ready = 1'b0;
        send_cmd(1'b1, 4'd0, 8'h00, 3'd0);
        for (int i = 0; i < 5; i++) begin
            check("bp_res_valid", 32'(res_valid), 32'd1);
            check("bp_res_data", 32'(res_data), 32'h00);
            check("bp_res_zero", 32'(res_zero), 32'd1);
            check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            cmd_valid = (i == 2);
            cmd_load  = 1'b1;
            cmd_data  = 8'h55;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("bp_after_release", 32'(res_data), 32'h00);

        // Gated key shift and reset during EXEC.
        @(negedge clk);
        check("exec_ready_in", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_load  = 1'b0;
        cmd_op    = OP_SHL;
        cmd_data  = 8'h00;
        cmd_rep   = 3'd7;
        @(negedge clk);
        cmd_valid = 1'b0;
        check("exec_cmd_ready", 32'(cmd_ready), 32'd0);
        check("exec_opcode", 32'(alu_opcode), 32'(OP_SHL));
        key_shift = 1'b1;
        key_sin   = 1'b1;
        @(negedge clk);
        key_shift = 1'b0;
        key_sin   = 1'b0;
        check("exec_key_hold", 32'(locking_key), 32'hD2);
        check("exec_loaded_hold", 32'(key_loaded), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_acc", 32'(res_data), 32'h00);
        check("mid_rst_key_loaded", 32'(key_loaded), 32'd0);
        check("mid_rst_key", 32'(locking_key), 32'd0);
        check("mid_rst_opcode", 32'(alu_opcode), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        acc_model = '0;

        // Recovery: reload key and run one command.
        load_key(8'hA5);
        send_cmd(1'b1, 4'd0, 8'h42, 3'd0);
        send_cmd(1'b0, OP_ROL, 8'h00, 3'd1);
        repeat (3) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_issue_ctrl
`default_nettype wire

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequential command front-end for the 8-bit `alu` datapath. It accepts commands over a valid/ready handshake and drives the ALU's `A`, `B` and `opcode` inputs from an internal accumulator and operand register. It captures `Y` back into the accumulator, optionally over several repeat cycles, and returns the result over a second valid/ready handshake. It also owns the serial loader that produces the ALU's `locking_key`.

## Interface
Parameters:
- `DW`, 8, datapath width; must match `alu`.
- `RW`, 3, width of the repeat count field.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `key_sin`  in  1  serial key bit, MSB first.
- `key_shift`  in  1  shift enable for `key_sin`.
- `locking_key`  out  8  key register, driven to `alu.locking_key`.
- `key_loaded`  out  1  high once 8 bits have been shifted in.
- `cmd_valid` / `cmd_ready`  in/out  1  command handshake.
- `cmd_load`  in  1  1 = load ACC with `cmd_data`; 0 = execute ALU op.
- `cmd_op`  in  4  ALU opcode.
- `cmd_data`  in  DW  immediate B operand, or load value.
- `cmd_rep`  in  RW  extra repeat count; the op executes `cmd_rep`+1 times.
- `alu_a` / `alu_b` / `alu_opcode`  out  DW/DW/4  to ALU `A`/`B`/`opcode`.
- `alu_y`  in  DW  from ALU `Y`.
- `res_valid` / `res_ready`  out/in  1  result handshake.
- `res_data`  out  DW  result, equal to ACC.
- `res_zero`  out  1  high when ACC == 0.

## Operation
- **FSM states:** IDLE, EXEC, RESP.
- **IDLE**
  - `cmd_ready = key_loaded`.
  - On `cmd_valid & cmd_ready`, latch `cmd_op`→OPR, `cmd_data`→BR and `cmd_rep`→CNT.
  - If `cmd_load`: ACC←`cmd_data`, go to RESP.
  - Else: go to EXEC.
- **EXEC**
  - Each cycle ACC←`alu_y`.
  - If CNT==0, go to RESP; else CNT←CNT−1.
  - Commands are not accepted.
- **RESP**
  - `res_valid = 1`.
  - On `res_ready`, go to IDLE.
  - `res_data` and `res_zero` are stable while `res_valid` is high.
- **ALU drive**
  - `alu_a` = ACC and `alu_b` = BR in all states.
  - `alu_opcode` = OPR in EXEC; 4'b0000 (CLR) otherwise.
- **Key loader**
  - On `key_shift` while the FSM is in IDLE, `locking_key` ← {`locking_key`[6:0], `key_sin`}.
  - A 4-bit bit counter increments and saturates at 8.
  - `key_loaded` = (counter == 8).
  - `key_shift` in EXEC or RESP is ignored, so the key is never changed mid-operation.
  - Shifting after the key is loaded keeps shifting; `key_loaded` stays 1.
- **Arithmetic:** ACC width is DW; ALU wrap-around is taken as-is, with no carry or overflow kept.

## Timing
- **Reset values:** state = IDLE; ACC, BR, OPR, CNT, `locking_key` and bit counter = 0. Outputs at reset: `key_loaded` = 0, `cmd_ready` = 0, `res_valid` = 0, `res_data` = 0x00, `res_zero` = 1, `alu_opcode` = 0.
- **Load command:** accepted at edge T; `res_valid` is high from the cycle after T.
- **Op command:** accepted at edge T; ACC updates at edges T+1..T+`cmd_rep`+1; `res_valid` is high from the cycle after edge T+`cmd_rep`+1.
- **Throughput:** minimum of one IDLE cycle between results. `cmd_ready` is low in EXEC and RESP.
- **Back-pressure:** `res_ready` held low keeps RESP indefinitely with ACC unchanged.
- **Reset mid-operation:** `rst_n` low in any state returns immediately to the reset values and discards the in-flight command. The key must be reloaded afterwards.
- **Simultaneous key and command in IDLE:**
  - `key_shift` and a command handshake in the same cycle are both honoured.
  - `cmd_ready` reflects `key_loaded` before the edge.

## Structure
- The shared package holds:
  - FSM state enum (IDLE/EXEC/RESP).
  - `KEY_BITS` = 8.
  - Opcode constant `OP_CLR` = 4'b0000.
- One natural sub-module: `lock_key_loader`, containing the shift register, saturating bit counter and `key_loaded`.
- `alu` is instantiated by the parent, not inside this block.

## Test plan
- **Reset and key load:** hold `rst_n` low, then shift 0xD2 MSB-first with `key_shift`. Required: `locking_key` = 0xD2; `key_loaded` rises on the 8th shift edge; `cmd_ready` is 0 before that and 1 after.
- **Load:** `cmd_load`=1, `cmd_data`=0x03. Required: `res_valid` the next cycle, `res_data` = 0x03, `res_zero` = 0.
- **Repeated shift:** ACC = 0x03; op 4'b1000 (SHL), `cmd_rep`=2. Required: ACC is 0x06, 0x0C, 0x18 on successive edges; `res_valid` 3 cycles after accept; `res_data` = 0x18.
- **Rotate and AND:** ROL 4'b0101 on ACC = 0x81 with `cmd_rep`=0 → 0x03. AND 4'b1111 with `cmd_data`=0x0F on ACC = 0x3C → 0x0C.
- **Back-pressure and zero flag:** load 0x00 and hold `res_ready` low for 5 cycles. Required: `res_valid` stays 1, `res_data` stays 0x00, `res_zero` = 1, and a `cmd_valid` pulse is not accepted.
- **Mid-op reset and gated key shift:** pulse `key_shift` during EXEC → `locking_key` unchanged. Assert `rst_n` low during EXEC → state is IDLE, ACC = 0, `key_loaded` = 0, `res_valid` = 0.
